calib_sequencer: RTL and testbench

CALIB_SEQUENCER -- requirements
Module: calib_sequencer

---
 rtl/calib_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_calib_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calib_sequencer.sv
// Calibration sequencer: steps PUCK/PADDLE1/PADDLE2 through settle, capture and HSV adjust.
// Optional frame-based auto-advance in WAIT_ENTER/ADJUST is built when CALIB_TIMEOUT_EN is defined.
module calib_sequencer #(
    parameter int         SETTLE_FRAMES  = 4,
    parameter int         TIMEOUT_FRAMES = 120,
    parameter logic [1:0] PUCK           = 2'd0,
    parameter logic [1:0] PADDLE1        = 2'd1,
    parameter logic [1:0] PADDLE2        = 2'd2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       frame_done,
    input  logic       btn_enter,
    input  logic       btn_next,
    input  logic       btn_abort,
    output logic [1:0] obj_sel,
    output logic [1:0] hsv_sel,
    output logic       enter_pulse,
    output logic       enable_threshold,
    output logic       busy,
    output logic       done,
    output logic [2:0] state,
    output logic       timeout_hit
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SETTLE     = 3'd1,
        S_WAIT_ENTER = 3'd2,
        S_CAPTURE    = 3'd3,
        S_ADJUST     = 3'd4,
        S_DONE       = 3'd5
    } state_e;

    localparam int E_START = 0;
    localparam int E_NEXT  = 1;
    localparam int E_ENTER = 2;
    localparam int E_ABORT = 3;

    localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_FRAMES);

    if (SETTLE_FRAMES < 1 || SETTLE_FRAMES > 15) begin : g_bad_settle
        $error("calib_sequencer: SETTLE_FRAMES must be 1..15");
    end
    if (TIMEOUT_FRAMES < 1 || TIMEOUT_FRAMES > 255) begin : g_bad_timeout
        $error("calib_sequencer: TIMEOUT_FRAMES must be 1..255");
    end

    state_e     state_q, state_d;
    logic [1:0] obj_q, obj_d;
    logic [1:0] hsv_q, hsv_d;
    logic [7:0] cnt_q, cnt_d;
    logic       enter_pulse_q, enter_pulse_d;
    logic [3:0] btn_in;
    logic [3:0] hist_q, hist_d;
    logic [3:0] edge_q, edge_d;
    logic       tmo_enter, tmo_next;
    logic       enter_go, next_go;

    // Edges are registered, so a press acts one clock after it is first sampled.
    assign btn_in = {btn_abort, btn_enter, btn_next, start};

    always_comb begin
        hist_d = btn_in;
        edge_d = btn_in & ~hist_q;
    end

    assign enter_go = edge_q[E_ENTER] | tmo_enter;
    assign next_go  = edge_q[E_NEXT]  | tmo_next;

    always_comb begin
        state_d = state_q;
        obj_d   = obj_q;
        hsv_d   = hsv_q;
        cnt_d   = cnt_q;
        if (edge_q[E_ABORT] && state_q != S_IDLE) begin
            state_d = S_IDLE;
            obj_d   = PUCK;
            hsv_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (edge_q[E_START]) begin
                        state_d = S_SETTLE;
                        obj_d   = PUCK;
                        hsv_d   = 2'd0;
                        cnt_d   = 8'd0;
                    end
                end
                S_SETTLE: begin
                    if (frame_done) begin
                        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        if (cnt_q >= SETTLE_LIM - 8'd1) state_d = S_WAIT_ENTER;
                    end
                end
                S_WAIT_ENTER: begin
                    if (enter_go) state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    state_d = S_ADJUST;
                    hsv_d   = 2'd0;
                end
                S_ADJUST: begin
                    if (enter_go) begin
                        state_d = S_CAPTURE;
                        hsv_d   = 2'd0;
                    end else if (next_go) begin
                        if (hsv_q != 2'd3) begin
                            hsv_d = hsv_q + 2'd1;
                        end else if (obj_q == PADDLE2) begin
                            state_d = S_DONE;
                        end else begin
                            obj_d   = (obj_q == PUCK) ? PADDLE1 : PADDLE2;
                            state_d = S_SETTLE;
                            hsv_d   = 2'd0;
                            cnt_d   = 8'd0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        enter_pulse_d = (state_d == S_CAPTURE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            obj_q         <= PUCK;
            hsv_q         <= 2'd0;
            cnt_q         <= 8'd0;
            enter_pulse_q <= 1'b0;
            hist_q        <= 4'd0;
            edge_q        <= 4'd0;
        end else begin
            state_q       <= state_d;
            obj_q         <= obj_d;
            hsv_q         <= hsv_d;
            cnt_q         <= cnt_d;
            enter_pulse_q <= enter_pulse_d;
            hist_q        <= hist_d;
            edge_q        <= edge_d;
        end
    end

`ifdef CALIB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_FRAMES);

    logic [7:0] tcnt_q, tcnt_d;
    logic       tmo_hit_q, tmo_hit_d;

    // A real edge in the same cycle wins; the timeout only fills in for a missing press.
    always_comb begin
        tmo_enter = 1'b0;
        tmo_next  = 1'b0;
        if (!edge_q[E_ABORT] && !edge_q[E_ENTER] && frame_done && tcnt_q >= TMO_LIM - 8'd1) begin
            if (state_q == S_WAIT_ENTER)                 tmo_enter = 1'b1;
            else if (state_q == S_ADJUST && !edge_q[E_NEXT]) tmo_next = 1'b1;
        end
        tmo_hit_d = tmo_enter | tmo_next;
    end

    // Any accepted enter/next changes either the state or hsv_sel, which restarts the count.
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_d != state_q || hsv_d != hsv_q) begin
            tcnt_d = 8'd0;
        end else if (frame_done && (state_q == S_WAIT_ENTER || state_q == S_ADJUST)) begin
            tcnt_d = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q    <= 8'd0;
            tmo_hit_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            tmo_hit_q <= tmo_hit_d;
        end
    end

    assign timeout_hit = tmo_hit_q;
`else
    assign tmo_enter   = 1'b0;
    assign tmo_next    = 1'b0;
    assign timeout_hit = 1'b0;
`endif

    assign obj_sel          = obj_q;
    assign hsv_sel          = hsv_q;
    assign enter_pulse      = enter_pulse_q;
    assign state            = state_q;
    assign enable_threshold = (state_q == S_ADJUST);
    assign done             = (state_q == S_DONE);
    assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_calib_sequencer.sv
// Directed + random bench for calib_sequencer against a frame/edge-level reference model.
module tb_calib_sequencer;

`ifdef CALIB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
    localparam int TMO    = 3;
`else
    localparam bit TMO_EN = 1'b0;
    localparam int TMO    = 120;
`endif
    localparam int SETTLE = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, frame_done = 1'b0;
    logic       btn_enter = 1'b0, btn_next = 1'b0, btn_abort = 1'b0;
    logic [1:0] obj_sel, hsv_sel;
    logic       enter_pulse, enable_threshold, busy, done, timeout_hit;
    logic [2:0] state;

    calib_sequencer #(
        .SETTLE_FRAMES(SETTLE), .TIMEOUT_FRAMES(TMO),
        .PUCK(2'd0), .PADDLE1(2'd1), .PADDLE2(2'd2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .frame_done(frame_done),
        .btn_enter(btn_enter), .btn_next(btn_next), .btn_abort(btn_abort),
        .obj_sel(obj_sel), .hsv_sel(hsv_sel), .enter_pulse(enter_pulse),
        .enable_threshold(enable_threshold), .busy(busy), .done(done),
        .state(state), .timeout_hit(timeout_hit)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ep_cnt = 0;
    int cap_q[$];

    // reference model: phase 0 idle,1 settle,2 wait,3 capture,4 adjust,5 done
    int m_st, m_obj, m_hsv, m_cnt, m_tc;
    bit m_ep, m_th;
    bit h_s, h_n, h_e, h_a;
    bit e_s, e_n, e_e, e_a;

    task automatic model_reset();
        m_st = 0; m_obj = 0; m_hsv = 0; m_cnt = 0; m_tc = 0; m_ep = 0; m_th = 0;
        {h_s, h_n, h_e, h_a} = 4'b0;
        {e_s, e_n, e_e, e_a} = 4'b0;
    endtask

    task automatic model_step(bit s, bit fd, bit en, bit nx, bit ab);
        int nst = m_st, nobj = m_obj, nhsv = m_hsv, ncnt = m_cnt, ntc = m_tc;
        bit ent = e_e, nxt = e_n, th = 1'b0;
        if (TMO_EN && fd && !e_a && !e_e && m_tc >= TMO - 1 &&
            (m_st == 2 || (m_st == 4 && !e_n))) begin
            th = 1'b1;
            if (m_st == 2) ent = 1'b1; else nxt = 1'b1;
        end
        if (e_a && m_st != 0) begin
            nst = 0; nobj = 0; nhsv = 0;
        end else begin
            case (m_st)
                0, 5: if (e_s) begin nst = 1; nobj = 0; nhsv = 0; ncnt = 0; end
                1: if (fd) begin
                    ncnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    if (ncnt >= SETTLE) nst = 2;
                end
                2: if (ent) nst = 3;
                3: begin nst = 4; nhsv = 0; end
                4: if (ent) begin nst = 3; nhsv = 0; end
                   else if (nxt) begin
                       if (m_hsv < 3) nhsv = m_hsv + 1;
                       else if (m_obj == 2) nst = 5;
                       else begin nobj = m_obj + 1; nst = 1; nhsv = 0; ncnt = 0; end
                   end
                default: nst = 0;
            endcase
        end
        if (nst != m_st || nhsv != m_hsv) ntc = 0;
        else if (fd && (m_st == 2 || m_st == 4)) ntc = (m_tc < 255) ? m_tc + 1 : 255;
        m_st = nst; m_obj = nobj; m_hsv = nhsv; m_cnt = ncnt; m_tc = ntc;
        m_ep = (nst == 3);
        m_th = TMO_EN ? th : 1'b0;
        e_s = s & ~h_s; e_n = nx & ~h_n; e_e = en & ~h_e; e_a = ab & ~h_a;
        h_s = s; h_n = nx; h_e = en; h_a = ab;
    endtask

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 8'(state), 8'(m_st));
        chk("obj_sel", 8'(obj_sel), 8'(m_obj));
        chk("hsv_sel", 8'(hsv_sel), 8'(m_hsv));
        chk("enter_pulse", 8'(enter_pulse), 8'(m_ep));
        chk("busy", 8'(busy), 8'(m_st != 0 && m_st != 5));
        chk("done", 8'(done), 8'(m_st == 5));
        chk("enable_threshold", 8'(enable_threshold), 8'(m_st == 4));
        chk("timeout_hit", 8'(timeout_hit), 8'(m_th));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step(start, frame_done, btn_enter, btn_next, btn_abort);
        #1;
        if (enter_pulse === 1'b1) begin
            ep_cnt++;
            cap_q.push_back(int'(obj_sel));
        end
        check_all();
    endtask

    task automatic press(int which);
        case (which)
            0: start = 1'b1;
            1: btn_next = 1'b1;
            2: btn_enter = 1'b1;
            default: btn_abort = 1'b1;
        endcase
        tick();
        {start, btn_next, btn_enter, btn_abort} = 4'b0;
        tick();
        tick();
    endtask

    task automatic settle();
        for (int i = 0; i < SETTLE; i++) begin
            frame_done = 1'b1; tick();
            frame_done = 1'b0; tick();
        end
    endtask

    initial begin
        int ep_snap;
        model_reset();
        // reset state
        #1; check_all();
        tick(); tick();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        reset_n = 1'b1;
        tick();

        // start edge then four frames; start held high must not retrigger
        start = 1'b1;
        tick();
        tick();
        chk("start_to_settle", 8'(state), 8'd1);
        chk("start_obj", 8'(obj_sel), 8'd0);
        for (int i = 0; i < SETTLE; i++) begin
            frame_done = 1'b1; tick();
            frame_done = 1'b0;
            chk("settle_count", 8'(state), (i == SETTLE - 1) ? 8'd2 : 8'd1);
            tick();
        end
        start = 1'b0;

        // capture strobe is exactly one cycle
        ep_cnt = 0; cap_q.delete();
        btn_enter = 1'b1;
        tick();
        chk("enter_lat", 8'(state), 8'd2);
        tick();
        chk("capture_state", 8'(state), 8'd3);
        chk("capture_pulse", 8'(enter_pulse), 8'd1);
        btn_enter = 1'b0;
        tick();
        chk("adjust_state", 8'(state), 8'd4);
        chk("pulse_one_cycle", 8'(enter_pulse), 8'd0);
        chk("adjust_hsv", 8'(hsv_sel), 8'd0);
        chk("adjust_thr", 8'(enable_threshold), 8'd1);

        // full pass through all three objects
        for (int o = 0; o < 3; o++) begin
            if (o > 0) begin
                settle();
                press(2);
            end
            for (int n = 0; n < 4; n++) press(1);
        end
        chk("pass_done", 8'(done), 8'd1);
        chk("pass_pulses", 8'(ep_cnt), 8'd3);
        chk("pass_caps", 8'(cap_q.size()), 8'd3);
        for (int i = 0; i < cap_q.size() && i < 3; i++)
            chk("pass_obj_seq", 8'(cap_q[i]), 8'(i));

        // abort outranks enter and next in the same cycle
        press(0);
        settle();
        press(2);
        chk("pre_abort_adj", 8'(state), 8'd4);
        ep_snap = ep_cnt;
        {btn_enter, btn_next, btn_abort} = 3'b111;
        tick();
        tick();
        chk("abort_state", 8'(state), 8'd0);
        chk("abort_obj", 8'(obj_sel), 8'd0);
        {btn_enter, btn_next, btn_abort} = 3'b000;
        tick();
        chk("abort_no_pulse", 8'(ep_cnt), 8'(ep_snap));

        // async reset mid-settle with enter held
        press(0);
        frame_done = 1'b1; tick(); frame_done = 1'b0; tick();
        frame_done = 1'b1; tick(); frame_done = 1'b0; tick();
        btn_enter = 1'b1;
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("rst_mid_state", 8'(state), 8'd0);
        chk("rst_mid_pulse", 8'(enter_pulse), 8'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("rst_release_idle", 8'(state), 8'd0);
        btn_enter = 1'b0;
        tick();

        // start held through reset release gives exactly one edge
        start = 1'b1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("held_start_edge", 8'(state), 8'd1);
        tick(); tick();
        chk("held_start_once", 8'(state), 8'd1);
        start = 1'b0;
        press(3);

`ifdef CALIB_TIMEOUT_EN
        // idle frames in WAIT_ENTER auto-capture
        press(0);
        settle();
        chk("tmo_wait", 8'(state), 8'd2);
        for (int i = 0; i < TMO; i++) begin
            frame_done = 1'b1; tick(); frame_done = 1'b0;
            if (i < TMO - 1) tick();
        end
        chk("tmo_hit", 8'(timeout_hit), 8'd1);
        chk("tmo_pulse", 8'(enter_pulse), 8'd1);
        tick();
        chk("tmo_adjust", 8'(state), 8'd4);
        chk("tmo_hit_clear", 8'(timeout_hit), 8'd0);
        press(3);
`endif

        // random stimulus against the model
        for (int c = 0; c < 2500; c++) begin
            frame_done = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) start = ~start;
            if ($urandom_range(0, 7) == 0)  btn_enter = ~btn_enter;
            if ($urandom_range(0, 3) == 0)  btn_next = ~btn_next;
            if ($urandom_range(0, 63) == 0) btn_abort = ~btn_abort;
            tick();
        end
        {start, frame_done, btn_enter, btn_next, btn_abort} = 5'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
